// File: rtl/repsub_divider.sv
// Sequential unsigned divider by repeated subtraction with a start/done handshake.
// Optional abort input enabled by defining REPSUB_DIVIDER_ABORT_EN.
module repsub_divider #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
`ifdef REPSUB_DIVIDER_ABORT_EN
    input  logic         abort,
`endif
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         busy,
    output logic         done,
    output logic         dbz
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t       state;
    state_t       next_state;
    logic [W-1:0] divisor_reg;
    logic         load;
    logic         sub;
    logic         set_dbz;
    logic         clear;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        sub        = 1'b0;
        set_dbz    = 1'b0;
        clear      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    next_state = S_ITER;
                end
            end
            S_ITER: begin
                busy = 1'b1;
`ifdef REPSUB_DIVIDER_ABORT_EN
                if (abort) begin
                    clear      = 1'b1;
                    next_state = S_IDLE;
                end else
`endif
                if (divisor_reg == '0) begin
                    set_dbz    = 1'b1;
                    next_state = S_DONE;
                end else if (remainder >= divisor_reg) begin
                    sub = 1'b1;
                end else begin
                    next_state = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    load       = 1'b1;
                    next_state = S_ITER;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Subtraction is guarded by the >= compare, so remainder never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quotient    <= '0;
            remainder   <= '0;
            divisor_reg <= '0;
            dbz         <= 1'b0;
        end else if (load) begin
            quotient    <= '0;
            remainder   <= dividend;
            divisor_reg <= divisor;
            dbz         <= 1'b0;
        end else if (clear) begin
            quotient  <= '0;
            remainder <= '0;
            dbz       <= 1'b0;
        end else if (set_dbz) begin
            dbz <= 1'b1;
        end else if (sub) begin
            remainder <= remainder - divisor_reg;
            quotient  <= quotient + 1'b1;
        end
    end

endmodule

// File: doc/repsub_divider.md
Name: repsub_divider

Overview:
- Sequential unsigned divider using repeated subtraction. It is the inverse operation of the team's repeated-addition multiplier.
- Self-contained FSM plus datapath: operand registers, quotient counter, comparator and subtractor.
- Sits beside the multiplier in the arithmetic unit. Uses the same start/done handshake, so the top level can drive either block.

Parameters:
- W, 8, operand/result width in bits (unsigned).

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a division; sampled on rising clk in IDLE or DONE
- dividend  input  W  unsigned dividend; captured on the start-accepting edge only
- divisor  input  W  unsigned divisor; captured on the start-accepting edge only
- quotient  output  W  quotient working register; final value valid while done=1
- remainder  output  W  remainder working register; final value valid while done=1
- busy  output  1  high while in ITER
- done  output  1  high while in DONE; results stable
- dbz  output  1  divide-by-zero flag; meaningful only while done=1

Behaviour:
- Reset (async, rst=1): state=IDLE. quotient=0, remainder=0, busy=0, done=0, dbz=0. Internal divisor register=0.
- States: IDLE, ITER, DONE. Encoded state register; default/illegal encoding returns to IDLE.
- IDLE:
  - start=1 at an edge: remainder<=dividend, divisor_reg<=divisor, quotient<=0, dbz<=0, go to ITER.
  - Else hold.
- ITER (busy=1), evaluated every edge:
  - divisor_reg==0: dbz<=1, go to DONE. quotient=0, remainder=dividend.
  - Else if remainder>=divisor_reg: remainder<=remainder-divisor_reg, quotient<=quotient+1, stay in ITER.
  - Else: go to DONE.
  - start is ignored in ITER.
- DONE (done=1, busy=0):
  - quotient, remainder and dbz are held stable.
  - Stays in DONE indefinitely while start=0.
  - start=1 at an edge: recapture operands exactly as in IDLE, go to ITER. done falls at that same edge.
- Latency:
  - done rises q+1 clocks after the start-accepting edge, where q is the final quotient.
  - Divide-by-zero: done rises 1 clock after the start-accepting edge.
  - Worst case: 2^W clocks (dividend=2^W-1, divisor=1).
- Arithmetic:
  - Unsigned W-bit compare and subtract. The subtract cannot underflow because it is guarded by >=.
  - quotient cannot overflow because quotient<=dividend.
- Boundaries:
  - dividend<divisor: zero subtractions; q=0, remainder=dividend.
  - dividend==divisor: q=1, remainder=0.
  - dividend=0 with divisor!=0: q=0, remainder=0, done after 1 clock.
  - Operand inputs changing during ITER/DONE: no effect.
  - rst asserted mid-ITER: immediate return to reset values; the operation is lost.
  - start held high continuously: each DONE lasts exactly 1 cycle before restarting with the current inputs.
- busy and done are never high simultaneously. Exactly one of IDLE/ITER/DONE is active.

Optional Feature:
- Macro: REPSUB_DIVIDER_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit), placed after start.
  - abort=1 at an edge while in ITER: go to IDLE, quotient<=0, remainder<=0, dbz<=0. done does not assert for the aborted operation.
  - abort is ignored in IDLE and DONE. If start and abort are both high in ITER, abort wins.
- Undefined: no abort port; ITER exits only via the rules above.

Test Plan:
- Basic: reset, then start with 7/2 -> busy for 4 clocks; done=1 with quotient=3, remainder=1, dbz=0; outputs held 10+ cycles while start=0.
- No subtraction: 5/7 -> done 1 clock after the accepting edge, quotient=0, remainder=5. Also 6/6 -> quotient=1, remainder=0, done after 2 clocks.
- Divide by zero: 9/0 -> done after 1 clock, dbz=1, quotient=0, remainder=9. Next start 8/4 -> dbz=0, quotient=2, remainder=0.
- Worst case (W=8): 255/1 -> done exactly 256 clocks after the accepting edge, quotient=255, remainder=0. Toggle start and operand inputs during ITER -> no effect on result.
- Reset mid-operation: start 200/3, assert rst asynchronously at ITER cycle 10 -> all outputs 0 immediately, state IDLE. After release, start 10/3 -> quotient=3, remainder=1.
- Abort (macro defined): start 100/1, abort at ITER cycle 5 -> IDLE next edge, done never asserts, outputs 0. Next start 10/5 -> quotient=2, remainder=0.
